// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised rx, mid-bit sampling, LSB-first frame capture.
// Latency: falling start edge to data_valid = 2 + CPP/2 + DATA_WIDTH*CPP + CPP cycles (+/-2).
// No backpressure: data_out holds the last good word; the consumer must take it within one frame.
module uart_rx #(
   parameter int CLOCKS_PER_PULSE = 16,
   parameter int DATA_WIDTH       = 8
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  rx,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   output logic                  frame_err,
   output logic                  rx_busy
);

   localparam int CW = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;
   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] CLK_MID  = CW'(CLOCKS_PER_PULSE/2 - 1);
   localparam logic [CW-1:0] CLK_LAST = CW'(CLOCKS_PER_PULSE - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic                    rx_m;
   logic                    rx_s;
   logic [CW-1:0]           c_clocks;
   logic [BW-1:0]           c_bits;
   logic [DATA_WIDTH-1:0]   shreg;
   logic                    bit_end;
   logic                    valid_nxt;
   logic                    err_nxt;

   // From the start-bit centre, one full bit period lands on the centre of every later bit.
   assign bit_end = (c_clocks == CLK_LAST);

   // Two-flop synchroniser; reset to the idle-high line level so reset release is not a start edge.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= RX_IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic: start detect, start-bit glitch rejection, data/stop sequencing, break hold.
   always_comb begin
      state_nxt = state;
      case (state)
         RX_IDLE:  if (!rx_s) state_nxt = RX_START;
         RX_START: if (c_clocks == CLK_MID) state_nxt = rx_s ? RX_IDLE : RX_DATA;
         RX_DATA:  if (bit_end && (c_bits == BIT_LAST)) state_nxt = RX_STOP;
         RX_STOP:  if (bit_end) state_nxt = rx_s ? RX_IDLE : RX_BREAK;
         RX_BREAK: if (rx_s) state_nxt = RX_IDLE;
         default:  state_nxt = RX_IDLE;
      endcase
   end

   // Output decode: strobe requests at the mid-stop decision, busy straight from state.
   always_comb begin
      valid_nxt = (state == RX_STOP) && bit_end && rx_s;
      err_nxt   = (state == RX_STOP) && bit_end && !rx_s;
      rx_busy   = (state != RX_IDLE);
   end

   // Bit-period and bit-index counters; both clear on every state change.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         c_clocks <= '0;
         c_bits   <= '0;
      end else if (state_nxt != state) begin
         c_clocks <= '0;
         c_bits   <= '0;
      end else if ((state == RX_DATA) && bit_end) begin
         c_clocks <= '0;
         c_bits   <= c_bits + 1'b1;
      end else if ((state == RX_START) || (state == RX_DATA) || (state == RX_STOP)) begin
         c_clocks <= c_clocks + 1'b1;
      end
   end

   // Shift in at the MSB and move right so the first (LSB) bit ends up at bit 0.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                          shreg <= '0;
      else if ((state == RX_DATA) && bit_end) shreg <= DATA_WIDTH'({rx_s, shreg} >> 1);
   end

   // Registered outputs: one-cycle strobes; data_out only moves on a good stop bit.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         data_out   <= '0;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         data_valid <= valid_nxt;
         frame_err  <= err_nxt;
         if (valid_nxt) data_out <= shreg;
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: behavioural serial driver, event scoreboard, directed scenarios.
// Expected strobes are queued with their nominal arrival cycle and checked every cycle.
// Literal expectations after each scenario pin the scoreboard itself.
module tb_uart_rx;
   localparam int CPP = 16;
   localparam int DW  = 8;
   localparam int LAT = 2 + CPP/2 + DW*CPP + CPP;

   logic          clk  = 1'b0;
   logic          rstn = 1'b0;
   logic          rx   = 1'b1;
   logic [DW-1:0] data_out;
   logic          data_valid;
   logic          frame_err;
   logic          rx_busy;

   uart_rx #(.CLOCKS_PER_PULSE(CPP), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rstn(rstn), .rx(rx),
      .data_out(data_out), .data_valid(data_valid), .frame_err(frame_err), .rx_busy(rx_busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int nvec = 0;
   int nerr = 0;

   typedef struct {
      bit            is_err;
      logic [DW-1:0] dat;
      int            t;
   } ev_t;

   ev_t           expq[$];
   logic [DW-1:0] model_last = '0;
   int            last_pulse_t = -1;
   int            n_valid = 0;
   int            n_err = 0;
   bit            prev_pulse = 1'b0;

   // Gap monitor for back-to-back frames
   bit btb_win = 1'b0;
   bit seen_busy = 1'b0;
   int low_run = 0;
   int max_gap = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Scoreboard compare, away from the active edge
   always @(negedge clk) begin
      if (!rstn) begin
         nvec++;
         if ({data_out, data_valid, frame_err, rx_busy} !== '0) begin
            nerr++;
            $display("FAIL reset_outputs: got dout=%h dv=%b fe=%b busy=%b expected all zero",
                     data_out, data_valid, frame_err, rx_busy);
         end
         prev_pulse = 1'b0;
      end else begin
         if (data_valid && frame_err) begin
            nvec++; nerr++;
            $display("FAIL strobe_exclusive: dv=%b fe=%b at cycle %0d", data_valid, frame_err, cyc);
         end
         if ((data_valid || frame_err) && prev_pulse) begin
            nvec++; nerr++;
            $display("FAIL strobe_width: strobe high two cycles in a row at cycle %0d", cyc);
         end
         if (data_valid || frame_err) begin
            last_pulse_t = cyc;
            if (data_valid) n_valid++;
            if (frame_err)  n_err++;
            if (expq.size() == 0) begin
               nvec++; nerr++;
               $display("FAIL unexpected_strobe: dv=%b fe=%b dout=%h at cycle %0d, none expected",
                        data_valid, frame_err, data_out, cyc);
            end else begin
               ev_t e;
               e = expq.pop_front();
               nvec++;
               if (e.is_err != frame_err) begin
                  nerr++;
                  $display("FAIL strobe_kind: got frame_err=%b expected %b at cycle %0d",
                           frame_err, e.is_err, cyc);
               end
               nvec++;
               if (cyc < e.t - 2 || cyc > e.t + 2) begin
                  nerr++;
                  $display("FAIL strobe_latency: got cycle %0d expected %0d +/-2", cyc, e.t);
               end
               if (!e.is_err) model_last = e.dat;
            end
         end else if (expq.size() > 0 && cyc > expq[0].t + 2) begin
            nvec++; nerr++;
            $display("FAIL missing_strobe: nothing by cycle %0d, expected near %0d", cyc, expq[0].t);
            void'(expq.pop_front());
         end
         nvec++;
         if (data_out !== model_last) begin
            nerr++;
            $display("FAIL data_out_hold: got %h expected %h at cycle %0d", data_out, model_last, cyc);
         end
         prev_pulse = data_valid || frame_err;
      end
   end

   // Busy-low gap measurement between back-to-back frames
   always @(negedge clk) begin
      if (btb_win) begin
         if (rx_busy) begin
            if (seen_busy && low_run > max_gap) max_gap = low_run;
            seen_busy = 1'b1;
            low_run = 0;
         end else if (seen_busy) begin
            low_run++;
         end
      end
   end

   // Drive rx for n bit-clock cycles; entered and left just after a rising edge
   task automatic hold(input logic v, input int n);
      rx = v;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input logic [DW-1:0] d, input logic stop, input bit expect_ev,
                             output int t0);
      ev_t e;
      t0 = cyc;
      if (expect_ev) begin
         e.is_err = !stop;
         e.dat    = d;
         e.t      = t0 + LAT;
         expq.push_back(e);
      end
      hold(1'b0, CPP);
      for (int i = 0; i < DW; i++) hold(d[i], CPP);
      hold(stop, CPP);
   endtask

   initial begin
      #500000;
      nerr++;
      $display("FAIL watchdog: bench did not finish by cycle %0d", cyc);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      int t0;
      int nv0;
      int ne0;
      int nb;
      int lastb;
      bit busy_ok;
      logic [DW-1:0] c3;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("reset_data_out", data_out, 32'h0);
      chk("reset_busy", rx_busy, 32'h0);
      rstn = 1'b1;
      hold(1'b1, 10);

      // 1: single frame 0xA5
      nv0 = n_valid;
      send_frame(8'hA5, 1'b1, 1'b1, t0);
      hold(1'b1, 20);
      chk("t1_data", data_out, 32'hA5);
      chk("t1_one_valid", n_valid - nv0, 32'd1);
      chk("t1_latency_window", (last_pulse_t - t0 >= 152) && (last_pulse_t - t0 <= 156), 32'd1);
      chk("t1_no_frame_err", n_err, 32'd0);

      // 2: back-to-back 0x00, 0xFF, 0x3C
      nv0 = n_valid;
      btb_win = 1'b1;
      send_frame(8'h00, 1'b1, 1'b1, t0);
      send_frame(8'hFF, 1'b1, 1'b1, t0);
      send_frame(8'h3C, 1'b1, 1'b1, t0);
      btb_win = 1'b0;
      hold(1'b1, 20);
      chk("t2_three_valid", n_valid - nv0, 32'd3);
      chk("t2_data_last", data_out, 32'h3C);
      chk("t2_gap_le_8", (max_gap > 0) && (max_gap <= 8), 32'd1);

      // 3: 3-cycle glitch
      nv0 = n_valid;
      ne0 = n_err;
      nb = 0;
      lastb = -1;
      t0 = cyc;
      for (int k = 0; k < 25; k++) begin
         rx = (k < 3) ? 1'b0 : 1'b1;
         @(posedge clk);
         #1;
         if (rx_busy) begin
            nb++;
            lastb = cyc - t0;
         end
      end
      chk("t3_busy_pulsed", nb > 0, 32'd1);
      chk("t3_idle_in_time", (lastb >= 0) && (lastb < CPP/2 + 3), 32'd1);
      chk("t3_no_strobes", (n_valid - nv0) + (n_err - ne0), 32'd0);
      hold(1'b1, 5);

      // 4: bad stop bit on 0x5A, then a good 0x81
      ne0 = n_err;
      send_frame(8'h5A, 1'b0, 1'b1, t0);
      busy_ok = 1'b1;
      for (int k = 0; k < 40; k++) begin
         hold(1'b0, 1);
         if (!rx_busy) busy_ok = 1'b0;
      end
      chk("t4_break_held", busy_ok, 32'd1);
      chk("t4_one_frame_err", n_err - ne0, 32'd1);
      chk("t4_data_kept", data_out, 32'h3C);
      hold(1'b1, 10);
      chk("t4_idle_after_release", rx_busy, 32'd0);
      send_frame(8'h81, 1'b1, 1'b1, t0);
      hold(1'b1, 20);
      chk("t4_good_after", data_out, 32'h81);

      // 5: line held low for 40 bit times
      nv0 = n_valid;
      ne0 = n_err;
      begin
         ev_t e;
         e.is_err = 1'b1;
         e.dat    = '0;
         e.t      = cyc + LAT;
         expq.push_back(e);
      end
      hold(1'b0, 40*CPP);
      hold(1'b1, 20);
      chk("t5_one_frame_err", n_err - ne0, 32'd1);
      chk("t5_no_valid", n_valid - nv0, 32'd0);
      chk("t5_data_kept", data_out, 32'h81);
      send_frame(8'h42, 1'b1, 1'b1, t0);
      hold(1'b1, 20);
      chk("t5_good_after", data_out, 32'h42);

      // 6: reset during bit 4 of 0xC3
      c3 = 8'hC3;
      hold(1'b0, CPP);
      for (int i = 0; i < 4; i++) hold(c3[i], CPP);
      hold(c3[4], CPP/2);
      rstn = 1'b0;
      #1;
      chk("t6_rst_data_out", data_out, 32'h0);
      chk("t6_rst_valid", data_valid, 32'h0);
      chk("t6_rst_frame_err", frame_err, 32'h0);
      chk("t6_rst_busy", rx_busy, 32'h0);
      model_last = '0;
      hold(1'b1, 5);
      rstn = 1'b1;
      nv0 = n_valid;
      hold(1'b1, 3*CPP);
      chk("t6_no_stale_frame", n_valid - nv0, 32'd0);
      chk("t6_data_after_reset", data_out, 32'h0);
      send_frame(8'hC3, 1'b1, 1'b1, t0);
      hold(1'b1, 20);
      chk("t6_good_after", data_out, 32'hC3);

      chk("queue_drained", expq.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
